// File: rtl/updown_counter_pkg.sv
// Shared types, constants and next-count rule for the up/down modulo counter.
// Saturation is only reachable when UPDOWN_COUNTER_SAT_EN is defined in the top.
package updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned DefaultWidth  = 8;
    localparam int unsigned DefaultPrescW = 4;
    localparam int unsigned MaxWidth      = 32;

    typedef logic [MaxWidth-1:0] cnt_t;

    // Returns {wrap, next}; callers zero-extend narrower counts into cnt_t.
    function automatic logic [MaxWidth:0] next_count(input cnt_t count, input cnt_t max_val,
                                                     input logic dir, input logic sat);
        logic wrap;
        cnt_t nxt;
        wrap = 1'b0;
        nxt  = count;
        case (dir)
            DIR_UP: begin
                if (count >= max_val) begin
                    wrap = 1'b1;
                    nxt  = sat ? max_val : '0;
                end else begin
                    nxt = count + cnt_t'(1);
                end
            end
            DIR_DOWN: begin
                if (count == '0) begin
                    wrap = 1'b1;
                    nxt  = sat ? '0 : max_val;
                end else if (count > max_val) begin
                    nxt = max_val;
                end else begin
                    nxt = count - cnt_t'(1);
                end
            end
            default: ;
        endcase
        return {wrap, nxt};
    endfunction

endpackage

// File: rtl/updown_counter_presc.sv
// Enable-gated prescaler: tick every div+1 enabled cycles, clr restarts the period.
module updown_counter_presc #(
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] div_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] pc_q, pc_d;

    assign tick_o = en_i && (pc_q == div_i);

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (en_i) begin
            pc_d = tick_o ? '0 : pc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down modulo counter with load, enable, prescaler and terminal-count pulse.
// Define UPDOWN_COUNTER_SAT_EN to add the sat_i port (saturate instead of wrap).
module updown_counter_mod
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned PRESC_W = DefaultPrescW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic               dir_i,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   load_val_i,
    input  logic [WIDTH-1:0]   max_val_i,
    input  logic [PRESC_W-1:0] presc_div_i,
`ifdef UPDOWN_COUNTER_SAT_EN
    input  logic               sat_i,
`endif
    output logic [WIDTH-1:0]   count_o,
    output logic               tc_o,
    output logic               zero_o
);

    logic             tick;
    logic             sat;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [MaxWidth:0] step_res;

`ifdef UPDOWN_COUNTER_SAT_EN
    assign sat = sat_i;
`else
    assign sat = 1'b0;
`endif

    updown_counter_presc #(
        .PRESC_W(PRESC_W)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .en_i  (en_i),
        .clr_i (load_i),
        .div_i (presc_div_i),
        .tick_o(tick)
    );

    assign step_res = next_count(cnt_t'(count_q), cnt_t'(max_val_i), dir_i, sat);

    if (WIDTH < MaxWidth) begin : g_unused
        logic unused_step_hi;
        assign unused_step_hi = ^step_res[MaxWidth-1:WIDTH];
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick) begin
            count_d = step_res[WIDTH-1:0];
            tc_d    = step_res[MaxWidth];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod: driver pushes expected results, monitor checks.
module tb_updown_counter_mod;

    localparam int PcMod = 16;
`ifdef UPDOWN_COUNTER_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] count;
        logic       tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, dir = 1'b1, load = 1'b0, sat = 1'b0;
    logic [7:0] load_val = '0, max_val = '0;
    logic [3:0] presc_div = '0;
    logic [7:0] count_o;
    logic       tc_o, zero_o;

    int   vectors = 0;
    int   miscompares = 0;
    int   m_count = 0;
    int   m_pc = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    updown_counter_mod #(
        .WIDTH  (8),
        .PRESC_W(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en),
        .dir_i      (dir),
        .load_i     (load),
        .load_val_i (load_val),
        .max_val_i  (max_val),
        .presc_div_i(presc_div),
`ifdef UPDOWN_COUNTER_SAT_EN
        .sat_i      (sat),
`endif
        .count_o    (count_o),
        .tc_o       (tc_o),
        .zero_o     (zero_o)
    );

    function automatic void check(input string name, input int unsigned act,
                                  input int unsigned req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    // Reference: a step moves the count one place along the ring 0..max_val,
    // out-of-range values fall back into range, and saturation blocks the ring ends.
    task automatic cycle();
        bit tick;
        bit tc;
        bit do_sat;
        @(posedge clk);
        do_sat = SatEn && sat;
        tick   = en && (m_pc == int'(presc_div));
        tc     = 1'b0;
        if (load) begin
            m_count = int'(load_val);
            m_pc    = 0;
        end else begin
            if (en) m_pc = tick ? 0 : (m_pc + 1) % PcMod;
            if (tick) begin
                if (dir) begin
                    if (m_count >= int'(max_val)) begin
                        tc      = 1'b1;
                        m_count = do_sat ? int'(max_val) : 0;
                    end else begin
                        m_count = m_count + 1;
                    end
                end else if (m_count == 0) begin
                    tc      = 1'b1;
                    m_count = do_sat ? 0 : int'(max_val);
                end else if (m_count > int'(max_val)) begin
                    m_count = int'(max_val);
                end else begin
                    m_count = m_count - 1;
                end
            end
        end
        exp_q.push_back('{count: 8'(m_count), tc: tc});
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        load_val = v;
        cycle();
        load = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("count", count_o, e.count);
            check("tc", tc_o, e.tc);
            check("zero", zero_o, e.count == 8'd0);
        end
    end

    initial begin
        #2;
        check("reset_count", count_o, 0);
        check("reset_zero", zero_o, 1);
        check("reset_tc", tc_o, 0);
        @(negedge clk);
        reset = 1'b0;

        // Wrap up, max 9, every cycle.
        max_val = 8'd9; presc_div = 4'd0; dir = 1'b1; en = 1'b1;
        do_load(8'd0);
        repeat (22) cycle();

        // Wrap down with prescaler, then freeze.
        max_val = 8'd5; presc_div = 4'd2; dir = 1'b0;
        do_load(8'd1);
        repeat (7) cycle();
        en = 1'b0;
        repeat (4) cycle();
        en = 1'b1;
        repeat (6) cycle();

        // Load priority and out-of-range values.
        max_val = 8'd100; presc_div = 4'd0; dir = 1'b1;
        do_load(8'd200);
        cycle();
        do_load(8'd200);
        dir = 1'b0;
        repeat (2) cycle();

        // Full-range wrap both ways.
        max_val = 8'd255; dir = 1'b1;
        do_load(8'd254);
        repeat (2) cycle();
        dir = 1'b0;
        repeat (2) cycle();

        // max_val = 0 pulses tc on every step.
        max_val = 8'd0; dir = 1'b1;
        repeat (3) cycle();
        dir = 1'b0;
        repeat (2) cycle();

        if (SatEn) begin
            sat = 1'b1; max_val = 8'd3; dir = 1'b1;
            do_load(8'd2);
            repeat (3) cycle();
            dir = 1'b0;
            repeat (6) cycle();
            do_load(8'd9);
            cycle();
            sat = 1'b0;
        end

        // Reset mid-count: asserted between edges, held over one edge.
        max_val = 8'd255; dir = 1'b1; presc_div = 4'd0; en = 1'b1;
        do_load(8'h37);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_count", count_o, 0);
        check("async_reset_zero", zero_o, 1);
        check("async_reset_tc", tc_o, 0);
        @(posedge clk);
        #1;
        check("held_reset_count", count_o, 0);
        @(negedge clk);
        reset = 1'b0;
        m_count = 0;
        m_pc = 0;
        repeat (3) cycle();

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) presc_div = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0)
                max_val = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            en       = ($urandom_range(0, 3) != 0);
            dir      = 1'($urandom);
            sat      = 1'($urandom);
            load     = ($urandom_range(0, 19) == 0);
            load_val = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 14));
            cycle();
        end
        load = 1'b0;

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
